// File: rtl/obstacle_monitor_pkg.sv
// Shared definitions for the obstacle monitor: line geometry, game constants,
// state encoding and the saturating score helper.
package obstacle_monitor_pkg;

   localparam int LINE_W            = 640;
   localparam int SCORE_W           = 16;
   localparam int PLAYER_W_DEF      = 32;
   localparam int LIVES_INIT_DEF    = 3;
   localparam int INVULN_SHIFTS_DEF = 40;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } state_e;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      logic [SCORE_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + {{(SCORE_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/obstacle_monitor_window_overlap.sv
// Clamps the player column so the window stays on screen, then ORs the
// PLAYER_W-bit slice of the obstacle line under the player.
module window_overlap
   import obstacle_monitor_pkg::*;
#(
   parameter int PLAYER_W = PLAYER_W_DEF
) (
   input  logic [LINE_W-1:0] line_i,
   input  logic [9:0]        player_x_i,
   output logic              overlap_o
);

   localparam logic [9:0] X_MAX = 10'(LINE_W - PLAYER_W);

   logic [9:0]          x_s;
   logic [PLAYER_W-1:0] slice_s;

   // Clamp, slice and reduce.
   always_comb begin
      x_s = player_x_i;
      if (player_x_i > X_MAX) begin
         x_s = X_MAX;
      end else begin
         x_s = player_x_i;
      end
      slice_s   = line_i[x_s +: PLAYER_W];
      overlap_o = |slice_s;
   end

endmodule

// File: rtl/obstacle_monitor.sv
// Per line-advance collision, lives/invulnerability and passed-obstacle
// scoring for the scrolling obstacle line.
module obstacle_monitor
   import obstacle_monitor_pkg::*;
#(
   parameter int PLAYER_W      = PLAYER_W_DEF,
   parameter int LIVES_INIT    = LIVES_INIT_DEF,
   parameter int INVULN_SHIFTS = INVULN_SHIFTS_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               start_i,
   input  logic               shift_i,
   input  logic [LINE_W-1:0]  line_i,
   input  logic [9:0]         player_x_i,
   output logic               hit_o,
   output logic [1:0]         lives_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [1:0]         state_o,
   output logic               game_over_o
);

   localparam int CNT_W = $clog2(INVULN_SHIFTS + 1);

   state_e             state_r;
   logic               hit_r;
   logic [1:0]         lives_r;
   logic [SCORE_W-1:0] score_r;
   logic               game_over_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               prev_r;
   logic               overlap_s;
   logic               passed_s;

   window_overlap #(.PLAYER_W(PLAYER_W)) u_window (
      .line_i     (line_i),
      .player_x_i (player_x_i),
      .overlap_o  (overlap_s)
   );

   // An obstacle has fully passed when column 639 falls from 1 to 0.
   assign passed_s = prev_r & ~line_i[LINE_W-1];

   // Game FSM with registered outputs; nothing moves while en_i is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         hit_r       <= 1'b0;
         lives_r     <= 2'd0;
         score_r     <= {SCORE_W{1'b0}};
         game_over_r <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         prev_r      <= 1'b0;
      end else begin
         hit_r <= 1'b0;
         if (en_i) begin
            case (state_r)
               ST_IDLE, ST_OVER: begin
                  if (start_i) begin
                     state_r     <= ST_RUN;
                     lives_r     <= 2'(LIVES_INIT);
                     score_r     <= {SCORE_W{1'b0}};
                     game_over_r <= 1'b0;
                     cnt_r       <= {CNT_W{1'b0}};
                     prev_r      <= line_i[LINE_W-1];
                  end else if (shift_i && (state_r == ST_OVER)) begin
                     prev_r <= line_i[LINE_W-1];
                  end
               end
               ST_RUN: begin
                  if (shift_i) begin
                     prev_r <= line_i[LINE_W-1];
                     if (passed_s) begin
                        score_r <= sat_inc(score_r);
                     end
                     if (overlap_s) begin
                        hit_r   <= 1'b1;
                        lives_r <= lives_r - 2'd1;
                        cnt_r   <= CNT_W'(INVULN_SHIFTS);
                        if (lives_r == 2'd1) begin
                           state_r     <= ST_OVER;
                           game_over_r <= 1'b1;
                        end else begin
                           state_r <= ST_HIT;
                        end
                     end
                  end
               end
               ST_HIT: begin
                  if (shift_i) begin
                     prev_r <= line_i[LINE_W-1];
                     if (passed_s) begin
                        score_r <= sat_inc(score_r);
                     end
                     if (cnt_r <= CNT_W'(1)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_RUN;
                     end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign hit_o       = hit_r;
   assign lives_o     = lives_r;
   assign score_o     = score_r;
   assign state_o     = state_r;
   assign game_over_o = game_over_r;

endmodule

// File: tb/tb_obstacle_monitor.sv
// Directed bench for obstacle_monitor: a behavioural game model queues the
// expected outputs each cycle and they are checked after the clock edge.
module tb_obstacle_monitor;
   import obstacle_monitor_pkg::*;

   logic              clk_i = 1'b0;
   logic              rst_ni, en_i, start_i, shift_i;
   logic [LINE_W-1:0] line_i;
   logic [9:0]        player_x_i;
   logic              hit_o, game_over_o;
   logic [1:0]        lives_o, state_o;
   logic [15:0]       score_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  st;
      logic [1:0]  lives;
      logic [15:0] score;
      logic        hit;
      logic        go;
   } exp_t;

   exp_t sb_q[$];

   // Reference game state.
   logic [1:0]  m_state, m_lives;
   logic [15:0] m_score;
   int          m_cnt;
   logic        m_prev, m_hit;

   obstacle_monitor dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .start_i     (start_i),
      .shift_i     (shift_i),
      .line_i      (line_i),
      .player_x_i  (player_x_i),
      .hit_o       (hit_o),
      .lives_o     (lives_o),
      .score_o     (score_o),
      .state_o     (state_o),
      .game_over_o (game_over_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic model_overlap(input logic [LINE_W-1:0] ln, input logic [9:0] x);
      int   xc;
      logic r;
      xc = (int'(x) > 608) ? 608 : int'(x);
      r  = 1'b0;
      for (int c = 0; c < 32; c++) r = r | ln[xc + c];
      return r;
   endfunction

   task automatic model_reset();
      m_state = 2'd0; m_lives = 2'd0; m_score = 16'd0;
      m_cnt = 0; m_prev = 1'b0; m_hit = 1'b0;
   endtask

   task automatic model_push();
      exp_t e;
      e.st = m_state; e.lives = m_lives; e.score = m_score;
      e.hit = m_hit; e.go = (m_state == 2'd3);
      sb_q.push_back(e);
   endtask

   // Apply one clock of the game rules to the model and queue its outputs.
   task automatic model_step();
      logic ov, fall;
      m_hit = 1'b0;
      ov    = model_overlap(line_i, player_x_i);
      fall  = m_prev && !line_i[639];
      if (en_i) begin
         if ((m_state == 2'd0 || m_state == 2'd3) && start_i) begin
            m_state = 2'd1; m_lives = 2'd3; m_score = 16'd0;
            m_cnt = 0; m_prev = line_i[639];
         end else if (shift_i && m_state != 2'd0) begin
            if (m_state != 2'd3 && fall)
               m_score = (m_score == 16'hFFFF) ? 16'hFFFF : m_score + 16'd1;
            m_prev = line_i[639];
            if (m_state == 2'd1 && ov) begin
               m_lives = m_lives - 2'd1;
               m_hit   = 1'b1;
               m_cnt   = 40;
               m_state = (m_lives == 2'd0) ? 2'd3 : 2'd2;
            end else if (m_state == 2'd2) begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) m_state = 2'd1;
            end
         end
      end
      model_push();
   endtask

   task automatic pop_check();
      exp_t e;
      chk("sb_depth", 16'(sb_q.size()), 16'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("state", 16'(state_o), 16'(e.st));
         chk("lives", 16'(lives_o), 16'(e.lives));
         chk("score", score_o, e.score);
         chk("hit", 16'(hit_o), 16'(e.hit));
         chk("game_over", 16'(game_over_o), 16'(e.go));
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk_i);
      #1;
      pop_check();
   endtask

   task automatic shifts(input int n);
      shift_i = 1'b1;
      repeat (n) cycle();
      shift_i = 1'b0;
   endtask

   task automatic set_range(input int lo, input int hi);
      line_i = '0;
      for (int c = lo; c <= hi; c++) line_i[c] = 1'b1;
   endtask

   initial begin
      rst_ni = 1'b0; en_i = 1'b1; start_i = 1'b0; shift_i = 1'b0;
      line_i = '0; player_x_i = 10'd100;
      model_reset();
      model_push();
      @(posedge clk_i);
      #1;
      pop_check();
      rst_ni = 1'b1;
      cycle();

      // Start a game.
      start_i = 1'b1; cycle(); start_i = 1'b0;
      chk("start_state", 16'(state_o), 16'd1);
      chk("start_lives", 16'(lives_o), 16'd3);

      // First hit, then invulnerability through 40 overlapping shifts.
      set_range(120, 199);
      shifts(1);
      chk("hit1_pulse", 16'(hit_o), 16'd1);
      chk("hit1_lives", 16'(lives_o), 16'd2);
      cycle();
      chk("hit1_drop", 16'(hit_o), 16'd0);
      start_i = 1'b1; cycle(); start_i = 1'b0;
      shifts(40);
      chk("invuln_done", 16'(state_o), 16'd1);

      // Second and third hits end the game.
      shifts(1);
      chk("hit2_lives", 16'(lives_o), 16'd1);
      line_i = '0;
      shifts(40);
      set_range(120, 199);
      shifts(1);
      chk("over_state", 16'(state_o), 16'd3);
      chk("over_flag", 16'(game_over_o), 16'd1);
      shifts(2);
      start_i = 1'b1; cycle(); start_i = 1'b0;
      chk("restart_lives", 16'(lives_o), 16'd3);

      // Scoring on the falling edge of column 639.
      set_range(639, 639); shifts(1);
      line_i = '0;         shifts(1);
      chk("score_first", score_o, 16'd1);
      set_range(639, 639); shifts(80);
      line_i = '0;         shifts(1);
      chk("score_held", score_o, 16'd2);

      // Saturation.
      force dut.score_r = 16'hFFFE;
      #1;
      release dut.score_r;
      m_score = 16'hFFFE;
      repeat (2) begin
         set_range(639, 639); shifts(1);
         line_i = '0;         shifts(1);
      end
      chk("score_sat", score_o, 16'hFFFF);

      // Clamped window reaches column 639.
      player_x_i = 10'd1000;
      set_range(639, 639);
      shifts(1);
      chk("clamp_hit", 16'(hit_o), 16'd1);
      line_i = '0;
      shifts(40);
      player_x_i = 10'd0;
      set_range(32, 32);
      shifts(1);
      chk("edge_nohit", 16'(hit_o), 16'd0);

      // Enable low freezes everything.
      set_range(31, 31);
      en_i = 1'b0; start_i = 1'b1;
      shifts(3);
      start_i = 1'b0;
      chk("en_low_hit", 16'(hit_o), 16'd0);
      en_i = 1'b1;
      shifts(1);
      chk("edge_hit", 16'(hit_o), 16'd1);
      shifts(3);

      // Reset in the middle of invulnerability.
      rst_ni = 1'b0;
      #1;
      model_reset();
      model_push();
      pop_check();
      chk("midreset_state", 16'(state_o), 16'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
